// File: rtl/pi_levels.sv
// pi_levels: priority-interrupt level controller; ON/GEN from CONO PI, PIR sampled by LOAD..TEST, arbitrated against PIH.
// Latency: LOAD to REQ_VALID is 4 cycles; HOLD_LEVEL follows REQ_ACK by one cycle.
// Backpressure: REQ_VALID/REQ_LEVEL hold until REQ_ACK or a CONO; optional GEN register under `ifdef PI_SOFT_GEN_EN.
module pi_levels #(
    parameter int LEVELS = 7,
    parameter int LW     = $clog2(LEVELS + 1)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              CONO_VALID,
    input  logic [6:0]        CONO_CMD,
    input  logic [LEVELS-1:0] CONO_MASK,
    input  logic [LEVELS-1:0] IO_REQ,
    input  logic              PI_DISABLE,
    input  logic              PI_CYCLE,
    input  logic              REQ_ACK,
    input  logic              DISMISS,
    output logic              REQ_VALID,
    output logic [LW-1:0]     REQ_LEVEL,
    output logic [LW-1:0]     HOLD_LEVEL,
    output logic [LEVELS-1:0] PIH,
    output logic [LEVELS-1:0] PIR,
    output logic [LEVELS-1:0] ON,
    output logic [LEVELS-1:0] GEN,
    output logic              ACTIVE
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT1, S_WAIT2, S_TEST, S_REQ} state_t;

    state_t            state;
    logic [LEVELS-1:0] on_q, gen_q, pih_q, pir_q;
    logic              active_q, cono_dly, req_vld_q;
    logic [LW-1:0]     req_lvl_q;

    logic              sys_clr, cono_apply, test_go;
    logic [LEVELS-1:0] on_nxt, pir_en, ack_mask, dis_mask;
    logic [LW-1:0]     hold_level, pir_first;
    logic              active_nxt;

    // Encoded number of the lowest set bit (highest priority); 0 when empty.
    function automatic logic [LW-1:0] first_set(input logic [LEVELS-1:0] v);
        first_set = '0;
        for (int i = LEVELS - 1; i >= 0; i--) begin
            if (v[i]) first_set = LW'(i + 1);
        end
    endfunction

    assign sys_clr    = CONO_VALID && CONO_CMD[0];
    assign cono_apply = CONO_VALID && !CONO_CMD[0];
    assign on_nxt     = (on_q & ~(CONO_CMD[4] ? CONO_MASK : '0)) | (CONO_CMD[3] ? CONO_MASK : '0);
    assign active_nxt = CONO_CMD[6] ? 1'b1 : (CONO_CMD[5] ? 1'b0 : active_q);
    assign pir_en     = {LEVELS{active_q}} & (gen_q | (on_q & IO_REQ));
    assign hold_level = first_set(pih_q);
    assign pir_first  = first_set(pir_q);
    assign test_go    = (pir_q != '0) && !PI_DISABLE &&
                        ((hold_level == '0) || (pir_first < hold_level));

    always_comb begin
        ack_mask = '0;
        dis_mask = '0;
        for (int i = 0; i < LEVELS; i++) begin
            ack_mask[i] = (state == S_REQ) && REQ_ACK && (req_lvl_q == LW'(i + 1));
            dis_mask[i] = DISMISS && (hold_level == LW'(i + 1));
        end
    end

`ifdef PI_SOFT_GEN_EN
    always_ff @(posedge CLK) begin
        if (!RESET_N || sys_clr) begin
            gen_q <= '0;
        end else if (cono_apply) begin
            gen_q <= (gen_q & ~(CONO_CMD[1] ? CONO_MASK : '0)) | (CONO_CMD[2] ? CONO_MASK : '0);
        end
    end
`else
    logic gen_cmd_unused;
    assign gen_cmd_unused = ^CONO_CMD[2:1];
    assign gen_q          = '0;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET_N || sys_clr) begin
            state     <= S_IDLE;
            on_q      <= '0;
            pih_q     <= '0;
            pir_q     <= '0;
            active_q  <= 1'b0;
            cono_dly  <= 1'b0;
            req_vld_q <= 1'b0;
            req_lvl_q <= '0;
        end else begin
            if (cono_apply) begin
                on_q     <= on_nxt;
                active_q <= active_nxt;
            end
            cono_dly <= CONO_VALID;
            // Dismiss clears the old highest level before an ack sets the new one.
            pih_q    <= (pih_q & ~dis_mask) | ack_mask;
            case (state)
                S_IDLE: begin
                    if (!CONO_VALID && !cono_dly && !PI_CYCLE) state <= S_LOAD;
                end
                S_LOAD: begin
                    pir_q <= pir_en;
                    state <= CONO_VALID ? S_IDLE : S_WAIT1;
                end
                S_WAIT1: state <= CONO_VALID ? S_IDLE : S_WAIT2;
                S_WAIT2: state <= CONO_VALID ? S_IDLE : S_TEST;
                S_TEST: begin
                    if (!CONO_VALID && test_go) begin
                        state     <= S_REQ;
                        req_vld_q <= 1'b1;
                        req_lvl_q <= pir_first;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (REQ_ACK) begin
                        pir_q     <= pir_q & ~ack_mask;
                        state     <= S_IDLE;
                        req_vld_q <= 1'b0;
                        req_lvl_q <= '0;
                    end else if (CONO_VALID) begin
                        state     <= S_IDLE;
                        req_vld_q <= 1'b0;
                        req_lvl_q <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign REQ_VALID  = req_vld_q;
    assign REQ_LEVEL  = req_lvl_q;
    assign HOLD_LEVEL = hold_level;
    assign PIH        = pih_q;
    assign PIR        = pir_q;
    assign ON         = on_q;
    assign GEN        = gen_q;
    assign ACTIVE     = active_q;

endmodule

// File: tb/tb_pi_levels.sv
// Self-checking bench for pi_levels (7 levels): directed scenarios plus randomized run against a behavioural model.
module tb_pi_levels;

    localparam logic [6:0] C_SYS_CLR = 7'h01, C_GEN_CLR = 7'h02, C_GEN_SET = 7'h04,
                           C_ON_SET  = 7'h08, C_ON_CLR  = 7'h10, C_ACT_OFF = 7'h20, C_ACT_ON = 7'h40;

    logic       clk, rst_n, cono_vld, pi_dis, pi_cyc, req_ack, dismiss;
    logic [6:0] cono_cmd, cono_mask, io_req;
    logic       req_vld, active;
    logic [2:0] req_lvl, hold_lvl;
    logic [6:0] pih, pir, on_o, gen_o;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: bit vectors plus a sequencer phase (0 idle, 1..3 load/wait, 4 test, 5 offering).
    bit [6:0] m_on, m_gen, m_pih, m_pir;
    bit       m_act, m_dly, m_vld;
    bit [2:0] m_lvl;
    int       m_ph;

    pi_levels #(.LEVELS(7)) dut (
        .CLK(clk), .RESET_N(rst_n), .CONO_VALID(cono_vld), .CONO_CMD(cono_cmd),
        .CONO_MASK(cono_mask), .IO_REQ(io_req), .PI_DISABLE(pi_dis), .PI_CYCLE(pi_cyc),
        .REQ_ACK(req_ack), .DISMISS(dismiss), .REQ_VALID(req_vld), .REQ_LEVEL(req_lvl),
        .HOLD_LEVEL(hold_lvl), .PIH(pih), .PIR(pir), .ON(on_o), .GEN(gen_o), .ACTIVE(active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit [2:0] lowest(input bit [6:0] v);
        for (int i = 0; i < 7; i++) if (v[i]) return 3'(i + 1);
        return 3'd0;
    endfunction

    // Advance one clock: predict the model's next state from current inputs, then step.
    task automatic tick();
        bit [6:0] n_on, n_gen, n_pih, n_pir;
        bit       n_act, n_vld;
        bit [2:0] n_lvl, h, p;
        int       n_ph;
        n_on = m_on; n_gen = m_gen; n_pih = m_pih; n_pir = m_pir;
        n_act = m_act; n_vld = m_vld; n_lvl = m_lvl; n_ph = m_ph;
        h = lowest(m_pih);
        p = lowest(m_pir);
        if (!rst_n || (cono_vld && cono_cmd[0])) begin
            n_on = 0; n_gen = 0; n_pih = 0; n_pir = 0;
            n_act = 0; n_vld = 0; n_lvl = 0; n_ph = 0;
        end else begin
            if (cono_vld) begin
                if (cono_cmd[4]) n_on = n_on & ~cono_mask;
                if (cono_cmd[3]) n_on = n_on | cono_mask;
`ifdef PI_SOFT_GEN_EN
                if (cono_cmd[1]) n_gen = n_gen & ~cono_mask;
                if (cono_cmd[2]) n_gen = n_gen | cono_mask;
`endif
                if (cono_cmd[5]) n_act = 0;
                if (cono_cmd[6]) n_act = 1;
            end
            if (dismiss && h != 0) n_pih[h-1] = 0;
            if (m_ph == 0) begin
                if (!cono_vld && !m_dly && !pi_cyc) n_ph = 1;
            end else if (m_ph == 1) begin
                n_pir = m_act ? (m_gen | (m_on & io_req)) : 7'h00;
                n_ph  = cono_vld ? 0 : 2;
            end else if (m_ph < 4) begin
                n_ph = cono_vld ? 0 : m_ph + 1;
            end else if (m_ph == 4) begin
                n_ph = 0;
                if (!cono_vld && p != 0 && !pi_dis && (h == 0 || p < h)) begin
                    n_ph = 5; n_vld = 1; n_lvl = p;
                end
            end else begin
                if (req_ack) begin
                    n_pih[m_lvl-1] = 1; n_pir[m_lvl-1] = 0;
                    n_ph = 0; n_vld = 0; n_lvl = 0;
                end else if (cono_vld) begin
                    n_ph = 0; n_vld = 0; n_lvl = 0;
                end
            end
        end
        @(posedge clk);
        m_on = n_on; m_gen = n_gen; m_pih = n_pih; m_pir = n_pir;
        m_act = n_act; m_vld = n_vld; m_lvl = n_lvl; m_ph = n_ph;
        m_dly = rst_n && cono_vld && !cono_cmd[0];
        #1;
    endtask

    task automatic do_cono(input logic [6:0] cmd, input logic [6:0] mask);
        cono_vld = 1; cono_cmd = cmd; cono_mask = mask;
        tick();
        cono_vld = 0; cono_cmd = 0; cono_mask = 0;
    endtask

    task automatic wait_req(input int budget, output int cyc);
        cyc = 0;
        while (!req_vld && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    task automatic pulse_ack(input logic with_dismiss);
        req_ack = 1; dismiss = with_dismiss;
        tick();
        req_ack = 0; dismiss = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        tick(); tick();
        n_cmp++; if (req_vld !== 1'b0) begin n_err++; $display("FAIL reset_req_valid got=%b want=0", req_vld); end
        n_cmp++; if (req_lvl !== 3'd0) begin n_err++; $display("FAIL reset_req_level got=%0d want=0", req_lvl); end
        n_cmp++; if (hold_lvl !== 3'd0) begin n_err++; $display("FAIL reset_hold_level got=%0d want=0", hold_lvl); end
        n_cmp++; if ({pih, pir, on_o, gen_o} !== 28'h0) begin n_err++; $display("FAIL reset_status got=%h want=0", {pih, pir, on_o, gen_o}); end
        n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL reset_active got=%b want=0", active); end
        rst_n = 1;
    endtask

    task automatic test_basic_request();
        int first = -1;
        io_req = 7'h08;
        do_cono(C_ACT_ON | C_ON_SET, 7'h7F);
        // strobe, delay, idle then LOAD, and LOAD+4 gives the offer 6 edges after the strobe
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (req_vld && first < 0) first = i;
        end
        n_cmp++; if (first != 6) begin n_err++; $display("FAIL basic_latency got=%0d want=6", first); end
        n_cmp++; if (req_lvl !== 3'd4) begin n_err++; $display("FAIL basic_level got=%0d want=4", req_lvl); end
        pulse_ack(0);
        n_cmp++; if (req_vld !== 1'b0) begin n_err++; $display("FAIL basic_drop got=%b want=0", req_vld); end
        n_cmp++; if (pih !== 7'h08) begin n_err++; $display("FAIL basic_pih got=%h want=08", pih); end
        n_cmp++; if (hold_lvl !== 3'd4) begin n_err++; $display("FAIL basic_hold got=%0d want=4", hold_lvl); end
    endtask

    task automatic test_hold_block();
        int seen = 0;
        int cyc;
        io_req = 7'h48;
        for (int i = 0; i < 14; i++) begin tick(); seen += int'(req_vld); end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL block_lower got=%0d want=0 offers", seen); end
        io_req = 7'h01;
        wait_req(10, cyc);
        n_cmp++; if (!(req_vld === 1'b1 && req_lvl === 3'd1)) begin n_err++; $display("FAIL preempt_level got=%b/%0d want=1/1", req_vld, req_lvl); end
        pulse_ack(0);
        n_cmp++; if (!(pih === 7'h09 && hold_lvl === 3'd1)) begin n_err++; $display("FAIL preempt_pih got=%h/%0d want=09/1", pih, hold_lvl); end
        io_req = 0;
        for (int i = 0; i < 6; i++) tick();
        dismiss = 1; tick(); dismiss = 0;
        n_cmp++; if (pih !== 7'h08) begin n_err++; $display("FAIL dismiss_pih got=%h want=08", pih); end
    endtask

    task automatic test_dismiss_with_ack();
        int cyc;
        io_req = 7'h02;
        wait_req(10, cyc);
        n_cmp++; if (req_lvl !== 3'd2) begin n_err++; $display("FAIL dis_ack_offer got=%0d want=2", req_lvl); end
        pulse_ack(1);
        n_cmp++; if (!(pih === 7'h02 && hold_lvl === 3'd2)) begin n_err++; $display("FAIL dis_ack_pih got=%h/%0d want=02/2", pih, hold_lvl); end
        io_req = 0;
        for (int i = 0; i < 6; i++) tick();
        dismiss = 1; tick(); dismiss = 0;
        n_cmp++; if (pih !== 7'h00) begin n_err++; $display("FAIL dis_empty got=%h want=00", pih); end
    endtask

    task automatic test_soft_gen();
        int cyc;
        io_req = 0;
        do_cono(C_GEN_SET, 7'h20);
        wait_req(12, cyc);
`ifdef PI_SOFT_GEN_EN
        n_cmp++; if (!(req_vld === 1'b1 && req_lvl === 3'd6)) begin n_err++; $display("FAIL gen_offer got=%b/%0d want=1/6", req_vld, req_lvl); end
        n_cmp++; if (gen_o !== 7'h20) begin n_err++; $display("FAIL gen_reg got=%h want=20", gen_o); end
        do_cono(C_GEN_CLR, 7'h20);
        n_cmp++; if (!(req_vld === 1'b0 && gen_o === 7'h00)) begin n_err++; $display("FAIL gen_clr got=%b/%h want=0/00", req_vld, gen_o); end
`else
        n_cmp++; if (req_vld !== 1'b0) begin n_err++; $display("FAIL gen_off_offer got=%b want=0", req_vld); end
        n_cmp++; if (gen_o !== 7'h00) begin n_err++; $display("FAIL gen_off_reg got=%h want=00", gen_o); end
`endif
    endtask

    task automatic test_sys_clear();
        int cyc;
        io_req = 7'h08;
        wait_req(12, cyc);
        pulse_ack(0);
        n_cmp++; if (pih !== 7'h08) begin n_err++; $display("FAIL sysclr_setup got=%h want=08", pih); end
        io_req = 7'h01;
        wait_req(12, cyc);
        n_cmp++; if (req_vld !== 1'b1) begin n_err++; $display("FAIL sysclr_offer got=%b want=1", req_vld); end
        do_cono(C_SYS_CLR | C_ON_SET, 7'h7F);
        n_cmp++; if (req_vld !== 1'b0) begin n_err++; $display("FAIL sysclr_valid got=%b want=0", req_vld); end
        n_cmp++; if ({on_o, pih} !== 14'h0) begin n_err++; $display("FAIL sysclr_on_pih got=%h want=0", {on_o, pih}); end
        n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL sysclr_active got=%b want=0", active); end
    endtask

    task automatic test_reset_mid();
        io_req = 7'h04;
        do_cono(C_ACT_ON | C_ON_SET, 7'h7F);
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (pir !== 7'h04) begin n_err++; $display("FAIL midrst_pir got=%h want=04", pir); end
        rst_n = 0; tick(); rst_n = 1;
        n_cmp++; if ({req_vld, req_lvl, hold_lvl, pih, pir, on_o, gen_o, active} !== 36'h0)
            begin n_err++; $display("FAIL midrst_outputs got=%h want=0", {req_vld, req_lvl, hold_lvl, pih, pir, on_o, gen_o, active}); end
    endtask

    task automatic test_disable();
        int seen = 0;
        int cyc;
        do_cono(C_ACT_ON | C_ON_SET, 7'h7F);
        pi_dis = 1; io_req = 7'h10;
        for (int i = 0; i < 20; i++) begin tick(); seen += int'(req_vld); end
        n_cmp++; if (seen != 0 || pir !== 7'h10) begin n_err++; $display("FAIL disable_block got=%0d/%h want=0/10", seen, pir); end
        pi_dis = 0;
        wait_req(5, cyc);
        n_cmp++; if (!(req_vld === 1'b1 && req_lvl === 3'd5)) begin n_err++; $display("FAIL disable_release got=%b/%0d want=1/5", req_vld, req_lvl); end
        pulse_ack(0);
        io_req = 0;
    endtask

    task automatic test_random();
        logic [35:0] got, exp;
        for (int i = 0; i < 3000; i++) begin
            rst_n    = ($urandom_range(0, 299) != 0);
            cono_vld = ($urandom_range(0, 11) == 0);
            cono_cmd = 7'($urandom) & 7'h7E;
            if ($urandom_range(0, 7) == 0) cono_cmd[0] = 1'b1;
            cono_mask = 7'($urandom);
            if ($urandom_range(0, 3) == 0) io_req = 7'($urandom);
            pi_dis  = ($urandom_range(0, 7) == 0);
            pi_cyc  = ($urandom_range(0, 7) == 0);
            req_ack = 1'($urandom_range(0, 1));
            dismiss = ($urandom_range(0, 7) == 0);
            tick();
            got = {req_vld, req_lvl, hold_lvl, pih, pir, on_o, gen_o, active};
            exp = {m_vld, m_lvl, lowest(m_pih), m_pih, m_pir, m_on, m_gen, m_act};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL random_cycle%0d got=%h want=%h", i, got, exp);
            end
        end
        rst_n = 1; cono_vld = 0; req_ack = 0; dismiss = 0; pi_dis = 0; pi_cyc = 0;
    endtask

    initial begin
        rst_n = 0; cono_vld = 0; cono_cmd = 0; cono_mask = 0; io_req = 0;
        pi_dis = 0; pi_cyc = 0; req_ack = 0; dismiss = 0;
        m_on = 0; m_gen = 0; m_pih = 0; m_pir = 0;
        m_act = 0; m_dly = 0; m_vld = 0; m_lvl = 0; m_ph = 0;
        test_reset();
        test_basic_request();
        test_hold_block();
        test_dismiss_with_ack();
        test_soft_gen();
        test_sys_clear();
        test_reset_mid();
        test_disable();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
